// File: rtl/csr_pkg.sv
// Shared constants and types for the CSR access unit: Zicsr funct3 encodings,
// operation and FSM state enums, and the read-only address field.
package csr_pkg;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  // csr[11:10] == 2'b11 marks a read-only CSR
  localparam logic [1:0] CSR_RO_FIELD = 2'b11;

  typedef enum logic [1:0] {
    OP_ILL = 2'b00,
    OP_RW  = 2'b01,
    OP_RS  = 2'b10,
    OP_RC  = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } state_e;

endpackage

// File: rtl/csr_access_unit_if.sv
// Request/response handshake between the execute stage (master) and the
// CSR access unit (slave).
interface csr_access_unit_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CSR_ADDR_W = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_funct3;
  logic [CSR_ADDR_W-1:0] req_csr;
  logic [XLEN-1:0]       req_rs1_val;
  logic [4:0]            req_rs1_idx;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [XLEN-1:0]       rsp_rdata;
  logic                  rsp_illegal;

  modport master (
    output req_valid, req_funct3, req_csr, req_rs1_val, req_rs1_idx, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_illegal
  );

  modport slave (
    input  req_valid, req_funct3, req_csr, req_rs1_val, req_rs1_idx, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_illegal
  );
endinterface

// File: rtl/csr_alu.sv
// Combinational Zicsr datapath: source select, new value, write enable and
// illegal decode. CSR_PRIV_CHECK_EN adds the read-only address check.
module csr_alu
  import csr_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
`ifdef CSR_PRIV_CHECK_EN
  input  logic            csr_ro,
`endif
  input  logic [4:0]      rs1_idx,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] old_val,
  output logic [XLEN-1:0] new_val,
  output logic            wen,
  output logic            illegal
);

  csr_op_e         op;
  logic [XLEN-1:0] src;
  logic            write_req;

  always_comb begin
    op = OP_ILL;
    unique case (funct3)
      F3_RW,  F3_RWI: op = OP_RW;
      F3_RS,  F3_RSI: op = OP_RS;
      F3_RC,  F3_RCI: op = OP_RC;
      default:        op = OP_ILL;
    endcase

    src = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_val;

    unique case (op)
      OP_RW:   new_val = src;
      OP_RS:   new_val = old_val | src;
      OP_RC:   new_val = old_val & ~src;
      default: new_val = '0;
    endcase

    // set/clear with rs1/zimm of zero must not write (side-effect-free read)
    write_req = (op == OP_RW) || (rs1_idx != 5'd0);
    illegal   = (op == OP_ILL);
`ifdef CSR_PRIV_CHECK_EN
    illegal   = illegal || (write_req && csr_ro);
`endif
    wen       = write_req && !illegal;
  end

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr initiator: serialises read / write / response over fixed FSM cycles.
// Optional read-only CSR check under CSR_PRIV_CHECK_EN.
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CSR_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  csr_access_unit_if.slave      req_bus,
  output logic [CSR_ADDR_W-1:0] csr_sel,
  output logic [XLEN-1:0]       csr_wdata,
  output logic                  csr_wen,
  input  logic [XLEN-1:0]       csr_rdata
);

  state_e                state, state_n;
  logic [2:0]            funct3_q;
  logic [CSR_ADDR_W-1:0] csr_q;
  logic [XLEN-1:0]       rs1_val_q;
  logic [4:0]            rs1_idx_q;
  logic [XLEN-1:0]       old_q, new_q;
  logic                  wen_q, illegal_q;

  logic [XLEN-1:0]       alu_new;
  logic                  alu_wen, alu_illegal;

  csr_alu #(.XLEN(XLEN)) u_alu (
    .funct3  (funct3_q),
`ifdef CSR_PRIV_CHECK_EN
    .csr_ro  (csr_q[CSR_ADDR_W-1 -: 2] == CSR_RO_FIELD),
`endif
    .rs1_idx (rs1_idx_q),
    .rs1_val (rs1_val_q),
    .old_val (csr_rdata),
    .new_val (alu_new),
    .wen     (alu_wen),
    .illegal (alu_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      funct3_q  <= '0;
      csr_q     <= '0;
      rs1_val_q <= '0;
      rs1_idx_q <= '0;
      old_q     <= '0;
      new_q     <= '0;
      wen_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (state == ST_IDLE && req_bus.req_valid) begin
        funct3_q  <= req_bus.req_funct3;
        csr_q     <= req_bus.req_csr;
        rs1_val_q <= req_bus.req_rs1_val;
        rs1_idx_q <= req_bus.req_rs1_idx;
      end
      if (state == ST_READ) begin
        old_q     <= alu_illegal ? '0 : csr_rdata;
        new_q     <= alu_new;
        wen_q     <= alu_wen;
        illegal_q <= alu_illegal;
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  if (req_bus.req_valid) state_n = ST_READ;
      ST_READ:  state_n = ST_WRITE;
      ST_WRITE: state_n = ST_RESP;
      ST_RESP:  if (req_bus.rsp_ready) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // all outputs decode the registered state only; csr_wen follows the async reset
  always_comb begin
    req_bus.req_ready   = (state == ST_IDLE);
    req_bus.rsp_valid   = (state == ST_RESP);
    req_bus.rsp_rdata   = (state == ST_RESP) ? old_q : '0;
    req_bus.rsp_illegal = (state == ST_RESP) && illegal_q;
    csr_sel             = (state == ST_READ || state == ST_WRITE) ? csr_q : '0;
    csr_wdata           = (state == ST_WRITE) ? new_q : '0;
    csr_wen             = (state == ST_WRITE) && wen_q;
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed self-checking bench for csr_access_unit with a behavioural
// combinational-read / negedge-write CSR file.
module tb_csr_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] csr_sel;
  logic [31:0] csr_wdata;
  logic        csr_wen;
  logic [31:0] csr_rdata;

  int checks = 0;
  int errors = 0;

  csr_access_unit_if #(.XLEN(32), .CSR_ADDR_W(12)) bus ();

  csr_access_unit #(.XLEN(32), .CSR_ADDR_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_bus   (bus),
    .csr_sel   (csr_sel),
    .csr_wdata (csr_wdata),
    .csr_wen   (csr_wen),
    .csr_rdata (csr_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] csr_mem [0:4095];
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  int          wen_cnt = 0;

  assign csr_rdata = csr_mem[csr_sel];

  always @(negedge clk) begin
    if (pre_en) csr_mem[pre_addr] <= pre_data;
    if (csr_wen) begin
      csr_mem[csr_sel] <= csr_wdata;
      wen_cnt <= wen_cnt + 1;
    end
  end

  task automatic preset(input logic [11:0] a, input logic [31:0] d);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    @(negedge clk); #1;
    pre_en = 1'b0;
  endtask

  // observations of the most recent transaction
  logic [11:0] o_sel1, o_sel2;
  logic        o_wen1, o_wen2, o_valid3, o_ill3, o_ready3, o_ready_after;
  logic [31:0] o_wdata2, o_rdata3;
  int          o_wdelta;

  task automatic run_txn(input logic [2:0] f3, input logic [11:0] a,
                         input logic [31:0] v, input logic [4:0] idx, input bit ack);
    int base;
    int n = 0;
    bus.rsp_ready = ack;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout: got %b expected 1", bus.req_ready);
    end
    base = wen_cnt;
    bus.req_valid = 1'b1; bus.req_funct3 = f3; bus.req_csr = a;
    bus.req_rs1_val = v; bus.req_rs1_idx = idx;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    o_sel1 = csr_sel; o_wen1 = csr_wen;
    @(posedge clk); #1;
    o_sel2 = csr_sel; o_wen2 = csr_wen; o_wdata2 = csr_wdata;
    @(posedge clk); #1;
    o_valid3 = bus.rsp_valid; o_rdata3 = bus.rsp_rdata;
    o_ill3 = bus.rsp_illegal; o_ready3 = bus.req_ready;
    o_wdelta = wen_cnt - base;
    if (ack) begin
      @(posedge clk); #1;
      o_ready_after = bus.req_ready;
    end
  endtask

  task automatic test_reset;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0", bus.rsp_rdata); end
    checks++; if (bus.rsp_illegal !== 1'b0) begin errors++; $display("FAIL reset_rsp_illegal: got %b expected 0", bus.rsp_illegal); end
    checks++; if (csr_wen !== 1'b0) begin errors++; $display("FAIL reset_csr_wen: got %b expected 0", csr_wen); end
    checks++; if (csr_sel !== 12'h0) begin errors++; $display("FAIL reset_csr_sel: got %h expected 0", csr_sel); end
    checks++; if (csr_wdata !== 32'h0) begin errors++; $display("FAIL reset_csr_wdata: got %h expected 0", csr_wdata); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_rw;
    preset(12'h300, 32'h0000_00F0);
    run_txn(3'b001, 12'h300, 32'h1234_5678, 5'd5, 1'b1);
    checks++; if (o_sel1 !== 12'h300) begin errors++; $display("FAIL rw_sel_read: got %h expected 300", o_sel1); end
    checks++; if (o_wen1 !== 1'b0) begin errors++; $display("FAIL rw_wen_read: got %b expected 0", o_wen1); end
    checks++; if (o_wen2 !== 1'b1) begin errors++; $display("FAIL rw_wen_write: got %b expected 1", o_wen2); end
    checks++; if (o_sel2 !== 12'h300) begin errors++; $display("FAIL rw_sel_write: got %h expected 300", o_sel2); end
    checks++; if (o_wdata2 !== 32'h1234_5678) begin errors++; $display("FAIL rw_wdata: got %h expected 12345678", o_wdata2); end
    checks++; if (o_valid3 !== 1'b1) begin errors++; $display("FAIL rw_rsp_valid: got %b expected 1", o_valid3); end
    checks++; if (o_rdata3 !== 32'h0000_00F0) begin errors++; $display("FAIL rw_rdata: got %h expected 000000f0", o_rdata3); end
    checks++; if (o_ill3 !== 1'b0) begin errors++; $display("FAIL rw_illegal: got %b expected 0", o_ill3); end
    checks++; if (o_ready3 !== 1'b0) begin errors++; $display("FAIL rw_ready_resp: got %b expected 0", o_ready3); end
    checks++; if (o_ready_after !== 1'b1) begin errors++; $display("FAIL rw_ready_after: got %b expected 1", o_ready_after); end
    checks++; if (o_wdelta !== 1) begin errors++; $display("FAIL rw_wen_pulses: got %0d expected 1", o_wdelta); end
    checks++; if (csr_mem[12'h300] !== 32'h1234_5678) begin errors++; $display("FAIL rw_readback: got %h expected 12345678", csr_mem[12'h300]); end
  endtask

  task automatic test_set_clear;
    preset(12'h305, 32'h0000_FF00);
    run_txn(3'b010, 12'h305, 32'h0000_00FF, 5'd3, 1'b1);
    checks++; if (o_rdata3 !== 32'h0000_FF00) begin errors++; $display("FAIL rs_rdata: got %h expected 0000ff00", o_rdata3); end
    checks++; if (o_wdata2 !== 32'h0000_FFFF) begin errors++; $display("FAIL rs_wdata: got %h expected 0000ffff", o_wdata2); end
    checks++; if (csr_mem[12'h305] !== 32'h0000_FFFF) begin errors++; $display("FAIL rs_readback: got %h expected 0000ffff", csr_mem[12'h305]); end
    preset(12'h340, 32'h0000_00FF);
    run_txn(3'b111, 12'h340, 32'hFFFF_FFFF, 5'h0F, 1'b1);
    checks++; if (o_rdata3 !== 32'h0000_00FF) begin errors++; $display("FAIL rci_rdata: got %h expected 000000ff", o_rdata3); end
    checks++; if (csr_mem[12'h340] !== 32'h0000_00F0) begin errors++; $display("FAIL rci_readback: got %h expected 000000f0", csr_mem[12'h340]); end
    checks++; if (o_wdelta !== 1) begin errors++; $display("FAIL rci_wen_pulses: got %0d expected 1", o_wdelta); end
  endtask

  task automatic test_suppressed;
    run_txn(3'b010, 12'h300, 32'hFFFF_FFFF, 5'd0, 1'b1);
    checks++; if (o_rdata3 !== 32'h1234_5678) begin errors++; $display("FAIL rs0_rdata: got %h expected 12345678", o_rdata3); end
    checks++; if (o_wen2 !== 1'b0) begin errors++; $display("FAIL rs0_wen: got %b expected 0", o_wen2); end
    checks++; if (o_wdelta !== 0) begin errors++; $display("FAIL rs0_wen_pulses: got %0d expected 0", o_wdelta); end
    checks++; if (o_ill3 !== 1'b0) begin errors++; $display("FAIL rs0_illegal: got %b expected 0", o_ill3); end
  endtask

  task automatic test_illegal;
    run_txn(3'b100, 12'h300, 32'hDEAD_BEEF, 5'd7, 1'b1);
    checks++; if (o_ill3 !== 1'b1) begin errors++; $display("FAIL ill100_flag: got %b expected 1", o_ill3); end
    checks++; if (o_rdata3 !== 32'h0) begin errors++; $display("FAIL ill100_rdata: got %h expected 0", o_rdata3); end
    checks++; if (o_wdelta !== 0) begin errors++; $display("FAIL ill100_wen_pulses: got %0d expected 0", o_wdelta); end
    run_txn(3'b000, 12'h300, 32'hDEAD_BEEF, 5'd7, 1'b1);
    checks++; if (o_ill3 !== 1'b1) begin errors++; $display("FAIL ill000_flag: got %b expected 1", o_ill3); end
    checks++; if (o_wdelta !== 0) begin errors++; $display("FAIL ill000_wen_pulses: got %0d expected 0", o_wdelta); end
    checks++; if (csr_mem[12'h300] !== 32'h1234_5678) begin errors++; $display("FAIL ill_readback: got %h expected 12345678", csr_mem[12'h300]); end
  endtask

  task automatic test_priv;
    logic        e_ill;
    logic [31:0] e_rd, e_mem;
    int          e_d;
`ifdef CSR_PRIV_CHECK_EN
    e_ill = 1'b1; e_rd = 32'h0; e_mem = 32'h0000_AAAA; e_d = 0;
`else
    e_ill = 1'b0; e_rd = 32'h0000_AAAA; e_mem = 32'h0000_0055; e_d = 1;
`endif
    preset(12'hC00, 32'h0000_AAAA);
    run_txn(3'b001, 12'hC00, 32'h0000_0055, 5'd4, 1'b1);
    checks++; if (o_ill3 !== e_ill) begin errors++; $display("FAIL ro_rw_illegal: got %b expected %b", o_ill3, e_ill); end
    checks++; if (o_rdata3 !== e_rd) begin errors++; $display("FAIL ro_rw_rdata: got %h expected %h", o_rdata3, e_rd); end
    checks++; if (o_wdelta !== e_d) begin errors++; $display("FAIL ro_rw_wen_pulses: got %0d expected %0d", o_wdelta, e_d); end
    checks++; if (csr_mem[12'hC00] !== e_mem) begin errors++; $display("FAIL ro_rw_readback: got %h expected %h", csr_mem[12'hC00], e_mem); end
    run_txn(3'b011, 12'hC00, 32'hFFFF_FFFF, 5'd0, 1'b1);
    checks++; if (o_ill3 !== 1'b0) begin errors++; $display("FAIL ro_rc0_illegal: got %b expected 0", o_ill3); end
    checks++; if (o_rdata3 !== e_mem) begin errors++; $display("FAIL ro_rc0_rdata: got %h expected %h", o_rdata3, e_mem); end
  endtask

  task automatic test_backpressure;
    int base;
    preset(12'h342, 32'h0000_ABCD);
    preset(12'h343, 32'h0000_0000);
    base = wen_cnt;
    run_txn(3'b010, 12'h342, 32'h000F_0000, 5'd2, 1'b0);
    checks++; if (o_valid3 !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid: got %b expected 1", o_valid3); end
    bus.req_valid = 1'b1; bus.req_funct3 = 3'b001; bus.req_csr = 12'h343;
    bus.req_rs1_val = 32'h0000_0001; bus.req_rs1_idx = 5'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0000_ABCD || bus.rsp_illegal !== 1'b0)
        begin errors++; $display("FAIL bp_hold_%0d: got valid=%b rdata=%h ill=%b expected valid=1 rdata=0000abcd ill=0", i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_illegal); end
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d: got %b expected 0", i, bus.req_ready); end
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b expected 1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after: got %b expected 0", bus.rsp_valid); end
    checks++; if (csr_mem[12'h342] !== 32'h000F_ABCD) begin errors++; $display("FAIL bp_readback: got %h expected 000fabcd", csr_mem[12'h342]); end
    checks++; if (csr_mem[12'h343] !== 32'h0) begin errors++; $display("FAIL bp_ignored_req: got %h expected 0", csr_mem[12'h343]); end
    checks++; if (wen_cnt - base !== 1) begin errors++; $display("FAIL bp_wen_pulses: got %0d expected 1", wen_cnt - base); end
  endtask

  task automatic test_back_to_back;
    int acc [$];
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_funct3 = 3'b001; bus.req_csr = 12'h344;
    bus.req_rs1_val = 32'h0000_0007; bus.req_rs1_idx = 5'd1;
    for (int i = 0; i < 12; i++) begin
      if (bus.req_ready) acc.push_back(i);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    checks++; if (acc.size() !== 3) begin errors++; $display("FAIL b2b_accepts: got %0d expected 3", acc.size()); end
    if (acc.size() == 3) begin
      checks++; if (acc[1] - acc[0] !== 4) begin errors++; $display("FAIL b2b_gap1: got %0d expected 4", acc[1] - acc[0]); end
      checks++; if (acc[2] - acc[1] !== 4) begin errors++; $display("FAIL b2b_gap2: got %0d expected 4", acc[2] - acc[1]); end
    end
    checks++; if (csr_mem[12'h344] !== 32'h0000_0007) begin errors++; $display("FAIL b2b_readback: got %h expected 00000007", csr_mem[12'h344]); end
  endtask

  task automatic test_reset_mid;
    int base;
    preset(12'h341, 32'h0000_1111);
    base = wen_cnt;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_funct3 = 3'b001; bus.req_csr = 12'h341;
    bus.req_rs1_val = 32'h0000_2222; bus.req_rs1_idx = 5'd1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (csr_wen !== 1'b1) begin errors++; $display("FAIL rstmid_wen_before: got %b expected 1", csr_wen); end
    rst = 1'b1;
    #1;
    checks++; if (csr_wen !== 1'b0) begin errors++; $display("FAIL rstmid_wen_async: got %b expected 0", csr_wen); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_idle: got %b expected 1", bus.req_ready); end
    checks++; if (csr_sel !== 12'h0) begin errors++; $display("FAIL rstmid_sel: got %h expected 0", csr_sel); end
    @(negedge clk); #1;
    rst = 1'b0;
    checks++; if (csr_mem[12'h341] !== 32'h0000_1111) begin errors++; $display("FAIL rstmid_readback: got %h expected 00001111", csr_mem[12'h341]); end
    checks++; if (wen_cnt - base !== 0) begin errors++; $display("FAIL rstmid_wen_pulses: got %0d expected 0", wen_cnt - base); end
    @(posedge clk); #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rsp_discarded: got %b expected 0", bus.rsp_valid); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_funct3 = '0; bus.req_csr = '0;
    bus.req_rs1_val = '0; bus.req_rs1_idx = '0; bus.rsp_ready = 1'b1;
    test_reset;
    test_rw;
    test_set_clear;
    test_suppressed;
    test_illegal;
    test_priv;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Initiator side of the core's CSR register file: accepts one decoded Zicsr instruction at a time from the execute stage, performs the read-modify-write sequence against the CSR file's select/wdata/wen/rdata port, and returns the old CSR value for write-back to `rd`. A small FSM serialises each access over fixed cycles, so the combinational-read / negedge-write CSR file is never read and written in the same cycle.

## Interface
- `XLEN`, 32: data width of CSR values and rs1 operand.
- `CSR_ADDR_W`, 12: CSR address width.

- `clk`  in  1  core clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_funct3`  in  3  Zicsr funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI).
- `req_csr`  in  CSR_ADDR_W  target CSR address.
- `req_rs1_val`  in  XLEN  rs1 register value (register forms).
- `req_rs1_idx`  in  5  rs1 index; also zimm for immediate forms.
- `rsp_valid`  out  1  response present; held until accepted.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_rdata`  out  XLEN  old CSR value (for `rd`).
- `rsp_illegal`  out  1  access was illegal; no write performed.
- `csr_sel`  out  CSR_ADDR_W  CSR file select.
- `csr_wdata`  out  XLEN  CSR file write data.
- `csr_wen`  out  1  CSR file write enable.
- `csr_rdata`  in  XLEN  CSR file combinational read data.

## Operation
- States: IDLE, READ, WRITE, RESP. Reset state IDLE.
- IDLE: `req_ready`=1. On `req_valid && req_ready` latch funct3, csr, rs1_val, rs1_idx -> READ.
- READ: `csr_sel`=latched csr; capture `csr_rdata` into old; compute new value; decide write enable -> WRITE.
- New value: RW: src; RS: old | src; RC: old & ~src. src = rs1_val for funct3[2]=0, zero-extended rs1_idx (zimm) for funct3[2]=1.
- Write suppressed for RS/RC/RSI/RCI when rs1_idx==0. RW/RWI always write.
- funct3 000 or 100: illegal; no write; rsp_rdata=0.
- WRITE: `csr_sel`=csr, `csr_wdata`=new, `csr_wen`=1 for the whole cycle iff write enabled and not illegal -> RESP.
- RESP: `rsp_valid`=1, `rsp_rdata`=old, `rsp_illegal` as decided; stay until `rsp_ready`, then -> IDLE.
- Outputs decoded from registered state only; no combinational path from `req_*` to `csr_*` or `rsp_*`.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_illegal`=0, `csr_wen`=0, `csr_sel`=0, `csr_wdata`=0.
- Accept edge at cycle 0; READ cycle 1; WRITE cycle 2 (CSR file commits on its falling edge); `rsp_valid` high from cycle 3.
- Back-to-back: next request accepted no earlier than the cycle after the response handshake (min 4-cycle throughput).
- `req_ready` low in READ/WRITE/RESP; requests there are ignored, not queued.
- `rsp_valid`/`rsp_rdata`/`rsp_illegal` stable while `rsp_ready`=0.
- `rst` mid-operation: immediate return to IDLE, `csr_wen` drops asynchronously, pending write and response discarded.
- `csr_sel` holds latched address in READ and WRITE; 0 in IDLE/RESP.

## Configuration
- `CSR_PRIV_CHECK_EN` defined: write to a read-only CSR (`req_csr[11:10]`==2'b11) with write enabled is illegal: `csr_wen` stays 0, `rsp_illegal`=1, `rsp_rdata`=0. Suppressed writes (RS/RC with rs1_idx 0) to read-only CSRs stay legal.
- Undefined: no address check; only funct3 000/100 are illegal.

## Structure
- `csr_pkg`: funct3 constants, `csr_op_e` (RW/RS/RC), FSM state enum, read-only address-field constant.
- One sub-module `csr_alu`: combinational src select, new-value compute, write-enable and illegal decode; FSM and latches stay in `csr_access_unit`.

## Test plan
- CSR 0x300 preset 0x0000_00F0; CSRRW rs1_val=0x1234_5678 -> rsp_rdata=0xF0 at cycle 3, `csr_wen` pulse in cycle 2, readback 0x1234_5678.
- CSR 0x305=0xFF00; CSRRS rs1_idx=3 rs1_val=0x00FF -> rdata 0xFF00, new 0xFFFF; CSRRCI zimm=0x0F on 0x340=0xFF -> new 0xF0.
- CSRRS rs1_idx=0 on 0x300 -> rdata returned, `csr_wen` never asserted.
- funct3=100 -> `rsp_illegal`=1, rdata 0, no write; with `CSR_PRIV_CHECK_EN`, CSRRW to 0xC00 -> illegal, no write; without it, write occurs.
- Hold `rsp_ready`=0 for 5 cycles -> response stable, `req_ready`=0, new `req_valid` ignored; assert `rst` during WRITE -> `csr_wen` falls immediately, FSM in IDLE, CSR unchanged if before falling edge.
